// File: rtl/jtag_debug_sys_pio_poller.sv
// jtag_debug_sys_pio_poller: Avalon-MM poller for the 32-bit input PIO, with change flag/count/irq (optional DEBOUNCE_EN).
module jtag_debug_sys_pio_poller #(
  parameter int DATA_W = 32,
  parameter int CNT_W = 16,
  parameter int INTERVAL_W = 16,
  parameter int DEBOUNCE_N = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [INTERVAL_W-1:0] interval,
  output logic [1:0]            avm_address,
  output logic                  avm_read,
  input  logic [DATA_W-1:0]     avm_readdata,
  output logic [DATA_W-1:0]     code_out,
  output logic                  code_valid,
  output logic                  code_changed,
  output logic [CNT_W-1:0]      change_count,
  output logic                  irq,
  input  logic                  irq_ack
);
  typedef enum logic [1:0] {IDLE, REQ, CAPT, WAIT} state_t;
  state_t state, state_nx;
  logic [INTERVAL_W-1:0] cnt, cnt_nx;
  logic acc, chg;
  assign avm_address = 2'd0;
  assign avm_read = state == REQ;
`ifdef DEBOUNCE_EN
  localparam int RUN_W = $clog2(DEBOUNCE_N + 1);
  logic [DATA_W-1:0] cand;
  logic [RUN_W-1:0] run, run_nx;
  assign run_nx = avm_readdata != cand ? RUN_W'(1) :
                  run == RUN_W'(DEBOUNCE_N) ? run : run + RUN_W'(1);
  assign acc = state == CAPT && run_nx == RUN_W'(DEBOUNCE_N);
  always_ff @(posedge clk) begin
    if (reset) begin
      cand <= '0;
      run <= '0;
    end else if (state == CAPT) begin
      cand <= avm_readdata;
      run <= run_nx;
    end
  end
`else
  assign acc = state == CAPT && DEBOUNCE_N > 0;
`endif
  assign chg = acc && code_valid && avm_readdata != code_out;
  always_comb begin
    state_nx = state;
    cnt_nx = state == CAPT ? interval : state == WAIT ? cnt - 1'b1 : cnt;
    case (state)
      IDLE: state_nx = enable ? REQ : IDLE;
      REQ:  state_nx = CAPT;
      CAPT: state_nx = !enable ? IDLE : interval == '0 ? REQ : WAIT;
      WAIT: state_nx = !enable ? IDLE : cnt <= INTERVAL_W'(1) ? REQ : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      code_out <= '0;
      code_valid <= 1'b0;
      code_changed <= 1'b0;
      change_count <= '0;
      irq <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (acc && (!code_valid || avm_readdata != code_out)) code_out <= avm_readdata;
      if (acc) code_valid <= 1'b1;
      code_changed <= chg;
      if (chg && !(&change_count)) change_count <= change_count + 1'b1;
      irq <= chg || (irq && !irq_ack);
    end
  end
endmodule
